move_arbiter: RTL

MOVE_ARBITER -- requirements
Module: move_arbiter

---
 rtl/move_arbiter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/move_arbiter.sv
// move_arbiter: grants one move at a time (auto > round-robin loc/rem) to the game datapath.
// Optional MOVE_ARB_STATS_EN adds an 8-bit saturating reject_count output.
module move_arbiter #(
    parameter int unsigned LOCKOUT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] turn_player,
    input  logic       loc_req,
    input  logic [1:0] loc_player,
    input  logic [2:0] loc_col,
    input  logic       rem_req,
    input  logic [1:0] rem_player,
    input  logic [2:0] rem_col,
    input  logic       auto_req,
    input  logic [2:0] auto_col,
    output logic       loc_ack,
    output logic       rem_ack,
    output logic       auto_ack,
    output logic       loc_nack,
    output logic       rem_nack,
    output logic       auto_nack,
    output logic       mv_valid,
    output logic [2:0] mv_col,
    output logic [1:0] mv_player,
    output logic [1:0] mv_src,
    input  logic       mv_done,
    input  logic       mv_ok,
    output logic       busy
`ifdef MOVE_ARB_STATS_EN
    ,
    output logic [7:0] reject_count
`endif
);

    // state   | meaning
    // IDLE    | sampling requests, granting or rejecting
    // ISSUE   | move latched, mv_valid raised on exit
    // WAIT    | mv_valid high, waiting for mv_done
    // LOCKOUT | enforced idle gap after a completed move
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_LOCKOUT = 2'd3;

    localparam logic [1:0] SRC_LOC  = 2'b00;
    localparam logic [1:0] SRC_REM  = 2'b01;
    localparam logic [1:0] SRC_AUTO = 2'b10;

    localparam logic [3:0] LOCK_LOAD = LOCKOUT_CYCLES[3:0];

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rr_q, rr_d;
    logic       mv_valid_q, mv_valid_d;
    logic [2:0] col_q, col_d;
    logic [1:0] player_q, player_d;
    logic [1:0] src_q, src_d;
    logic [2:0] ack_q, ack_d;
    logic [2:0] nack_q, nack_d;

    logic       loc_ok, rem_ok, pulse_now;
    logic       win_vld;
    logic [1:0] win_src;
    logic [2:0] win_col;
    logic [1:0] win_player;
    logic [2:0] win_onehot;
    logic [2:0] src_onehot;

    always_comb begin
        loc_ok     = loc_req && (loc_player == turn_player);
        rem_ok     = rem_req && (rem_player == turn_player);
        win_vld    = 1'b1;
        win_src    = SRC_AUTO;
        win_col    = auto_col;
        win_player = turn_player;
        win_onehot = 3'b100;
        if (auto_req) begin
            win_src = SRC_AUTO;
        end else if (loc_ok && (!rem_ok || !rr_q)) begin
            win_src    = SRC_LOC;
            win_col    = loc_col;
            win_player = loc_player;
            win_onehot = 3'b001;
        end else if (rem_ok) begin
            win_src    = SRC_REM;
            win_col    = rem_col;
            win_player = rem_player;
            win_onehot = 3'b010;
        end else begin
            win_vld    = 1'b0;
            win_onehot = 3'b000;
        end
    end

    always_comb begin
        src_onehot = 3'b000;
        case (src_q)
            SRC_LOC:  src_onehot = 3'b001;
            SRC_REM:  src_onehot = 3'b010;
            SRC_AUTO: src_onehot = 3'b100;
            default:  src_onehot = 3'b000;
        endcase
    end

    // Requests are level-held until the requester sees its pulse, so skip one
    // sampling cycle while a pulse is out to avoid rejecting the same request twice.
    assign pulse_now = (|ack_q) || (|nack_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        mv_valid_d = mv_valid_q;
        col_d      = col_q;
        player_d   = player_q;
        src_d      = src_q;
        ack_d      = 3'b000;
        nack_d     = 3'b000;
        case (state_q)
            ST_IDLE: begin
                if (enable && !pulse_now && win_vld) begin
                    if (win_col == 3'd7) begin
                        nack_d = win_onehot;
                    end else begin
                        state_d  = ST_ISSUE;
                        col_d    = win_col;
                        player_d = win_player;
                        src_d    = win_src;
                        if (win_src == SRC_LOC) begin
                            rr_d = 1'b1;
                        end else if (win_src == SRC_REM) begin
                            rr_d = 1'b0;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                mv_valid_d = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (mv_done) begin
                    mv_valid_d = 1'b0;
                    state_d    = ST_LOCKOUT;
                    cnt_d      = LOCK_LOAD;
                    if (mv_ok) begin
                        ack_d = src_onehot;
                    end else begin
                        nack_d = src_onehot;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            rr_q       <= 1'b0;
            mv_valid_q <= 1'b0;
            col_q      <= 3'd0;
            player_q   <= 2'd0;
            src_q      <= 2'd0;
            ack_q      <= 3'b000;
            nack_q     <= 3'b000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            mv_valid_q <= mv_valid_d;
            col_q      <= col_d;
            player_q   <= player_d;
            src_q      <= src_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
        end
    end

    assign loc_ack   = ack_q[0];
    assign rem_ack   = ack_q[1];
    assign auto_ack  = ack_q[2];
    assign loc_nack  = nack_q[0];
    assign rem_nack  = nack_q[1];
    assign auto_nack = nack_q[2];
    assign mv_valid  = mv_valid_q;
    assign mv_col    = col_q;
    assign mv_player = player_q;
    assign mv_src    = src_q;
    assign busy      = (state_q != ST_IDLE);

`ifdef MOVE_ARB_STATS_EN
    logic [7:0] rej_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rej_q <= 8'd0;
        end else if ((|nack_d) && (rej_q != 8'hFF)) begin
            rej_q <= rej_q + 8'd1;
        end
    end

    assign reject_count = rej_q;
`endif

endmodule
